// File: rtl/shake_pkg.sv
// Shared types for the SHAKE squeeze controller: mode and FSM enums, rate sizes, rate lookup.
package shake_pkg;

  localparam int RATE128_WORDS = 42;
  localparam int RATE256_WORDS = 34;

  typedef enum logic {
    SHAKE128 = 1'b0,
    SHAKE256 = 1'b1
  } shake_mode_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    READ     = 3'd2,
    PERMUTE  = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } sq_state_e;

  // PERMUTE is a three-step handshake: pulse next, see the core go busy, see it come back.
  typedef enum logic [1:0] {
    PH_PULSE   = 2'd0,
    PH_WAIT_LO = 2'd1,
    PH_WAIT_HI = 2'd2
  } perm_phase_e;

  function automatic logic [6:0] rate_words(input shake_mode_e m);
    return (m == SHAKE256) ? 7'(RATE256_WORDS) : 7'(RATE128_WORDS);
  endfunction

endpackage

// File: rtl/shake_sq_skid.sv
// Two-entry FIFO holding returned core words (data + last flag) until the consumer accepts them.
module shake_sq_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign w_pop  = pop && (r_cnt != 2'd0);
  assign w_push = push && ((r_cnt != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_cnt;

endmodule

// File: rtl/shake_squeeze_ctrl.sv
// SHAKE squeeze controller: streams rate words from the sha3 core, permuting between blocks.
// Define SHAKE_SQ_BSWAP_EN to byte-reverse each word for big-endian consumers.
module shake_squeeze_ctrl
  import shake_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int CORE_AW = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [LEN_W-1:0]   out_len,
  input  logic               core_ready,
  input  logic [31:0]        core_dout,
  output logic [CORE_AW-1:0] core_addr,
  output logic               core_next,
  output logic [31:0]        m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               busy,
  output logic               done
);

  sq_state_e    r_state;
  sq_state_e    w_state_next;
  perm_phase_e  r_phase;
  shake_mode_e  r_mode;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_rd_cnt;
  logic [6:0]   r_idx;
  logic         r_in_flight;
  logic         r_flight_last;

  logic [6:0]   w_rate;
  logic         w_all_read;
  logic         w_blk_end;
  logic         w_issue;
  logic [1:0]   w_skid_cnt;
  logic [31:0]  w_dout_sw;
  logic [32:0]  w_head;

`ifdef SHAKE_SQ_BSWAP_EN
  assign w_dout_sw = {core_dout[7:0], core_dout[15:8], core_dout[23:16], core_dout[31:24]};
`else
  assign w_dout_sw = core_dout;
`endif

  assign w_rate     = rate_words(r_mode);
  assign w_all_read = (r_rd_cnt == r_len);
  assign w_blk_end  = (r_idx == w_rate);
  // At most two words outstanding (in flight + buffered) so the skid can never overflow.
  assign w_issue    = (r_state == READ) && !w_all_read && !w_blk_end &&
                      (({1'b0, r_in_flight} + w_skid_cnt) < 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (start) w_state_next = (out_len == '0) ? DONE : WAIT_RDY;
      WAIT_RDY: if (core_ready) w_state_next = READ;
      READ: begin
        if (w_all_read)                    w_state_next = DRAIN;
        else if (w_blk_end && !r_in_flight) w_state_next = PERMUTE;
      end
      PERMUTE:  if (r_phase == PH_WAIT_HI && core_ready) w_state_next = READ;
      DRAIN:    if (w_skid_cnt == 2'd0 && !r_in_flight) w_state_next = DONE;
      DONE:     w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_comb begin
    core_next = (r_state == PERMUTE) && (r_phase == PH_PULSE);
    busy      = (r_state != IDLE);
    done      = (r_state == DONE);
    core_addr = CORE_AW'(r_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase       <= PH_PULSE;
      r_mode        <= SHAKE128;
      r_len         <= '0;
      r_rd_cnt      <= '0;
      r_idx         <= '0;
      r_in_flight   <= 1'b0;
      r_flight_last <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_mode   <= shake_mode_e'(mode);
        r_len    <= out_len;
        r_rd_cnt <= '0;
        r_idx    <= '0;
      end
      r_in_flight <= w_issue;
      if (w_issue) begin
        r_rd_cnt      <= r_rd_cnt + LEN_W'(1);
        r_idx         <= r_idx + 7'd1;
        r_flight_last <= (r_rd_cnt == r_len - LEN_W'(1));
      end
      if (r_state != PERMUTE) begin
        r_phase <= PH_PULSE;
      end else begin
        case (r_phase)
          PH_PULSE:   r_phase <= PH_WAIT_LO;
          PH_WAIT_LO: if (!core_ready) r_phase <= PH_WAIT_HI;
          default:    r_phase <= r_phase;
        endcase
        if (w_state_next == READ) r_idx <= '0;
      end
    end
  end

  shake_sq_skid #(.W(33)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_in_flight),
    .din   ({r_flight_last, w_dout_sw}),
    .pop   (m_valid && m_ready),
    .dout  (w_head),
    .count (w_skid_cnt)
  );

  assign m_valid = (w_skid_cnt != 2'd0);
  assign m_data  = w_head[31:0];
  assign m_last  = w_head[32];

endmodule

// File: tb/tb_shake_squeeze_ctrl.sv
// Self-checking bench for shake_squeeze_ctrl: behavioural sha3 core model plus word scoreboard.
module tb_shake_squeeze_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] out_len = '0;
  logic        core_ready;
  logic [31:0] core_dout;
  logic [6:0]  core_addr;
  logic        core_next;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic        busy;
  logic        done;

  shake_squeeze_ctrl #(.LEN_W(16), .CORE_AW(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .out_len(out_len),
    .core_ready(core_ready), .core_dout(core_dout), .core_addr(core_addr),
    .core_next(core_next), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sha3 core model: word contents encode permutation number and address
  logic mdl_ready = 1'b1;
  logic absorb_hold = 1'b0;
  int   perm = 0;
  int   busy_left = 0;
  assign core_ready = mdl_ready && !absorb_hold;

  function automatic logic [31:0] raw_word(input int p, input int a);
    return 32'h3C00_0000 | (32'(p) << 12) | (32'(a) * 32'h0000_0103);
  endfunction

  function automatic logic [31:0] exp_word(input int p, input int a);
    logic [31:0] w;
    w = raw_word(p, a);
`ifdef SHAKE_SQ_BSWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  always @(posedge clk) begin
    core_dout <= raw_word(perm, int'(core_addr));
    if (core_next) begin
      mdl_ready <= 1'b0;
      busy_left <= 4;
    end else if (busy_left != 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) begin
        mdl_ready <= 1'b1;
        perm      <= perm + 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // scoreboard and monitor
  logic [32:0] sb_q[$];
  int   next_cnt, done_cnt, valid_cnt, acc_cnt, done_cyc;
  logic prev_stall = 1'b0;
  logic prev_next  = 1'b0;
  logic [32:0] prev_word;
  logic [32:0] exp_w;
  logic rand_ready = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_next  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", {m_last, m_data}, prev_word);
      end
      if (m_valid) valid_cnt++;
      if (m_valid && m_ready) begin
        chk("sb_has_entry", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          exp_w = sb_q.pop_front();
          chk($sformatf("word%0d", acc_cnt), {m_last, m_data}, exp_w);
        end
        acc_cnt++;
      end
      if (core_next) begin
        next_cnt++;
        chk("next_core_ready", core_ready, 1);
        chk("next_single_cycle", prev_next, 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
      prev_next  = core_next;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end
  end

  typedef struct {
    logic md;
    int   len;
    bit   rnd;
    bit   hold;
    int   exp_next;
  } vec_t;

  vec_t vecs[8];

  task automatic clear_counters();
    next_cnt = 0; done_cnt = 0; valid_cnt = 0; acc_cnt = 0; done_cyc = -1;
  endtask

  task automatic load_expected(input logic md, input int len);
    int rate;
    int base;
    rate = md ? 34 : 42;
    base = perm;
    for (int i = 0; i < len; i++)
      sb_q.push_back({1'(i == len - 1), exp_word(base + i / rate, i % rate)});
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int st;
    clear_counters();
    rand_ready = v.rnd;
    if (!v.rnd) m_ready = 1'b1;
    load_expected(v.md, v.len);
    absorb_hold = v.hold;
    @(posedge clk); #1;
    mode = v.md; out_len = 16'(v.len); start = 1'b1; st = cyc;
    @(posedge clk); #1;
    start = 1'b0; mode = ~v.md; out_len = 16'hFFFF;
    if (v.hold) begin
      repeat (6) @(posedge clk);
      #1;
      chk("hold_no_valid", valid_cnt, 0);
      chk("hold_busy", busy, 1);
      absorb_hold = 1'b0;
    end
    if (v.len >= 10) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int k = 0; k < 5000 && done_cnt == 0; k++) @(posedge clk);
    chk("done_seen", done_cnt != 0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("done_once", done_cnt, 1);
    chk("next_count", next_cnt, v.exp_next);
    chk("word_count", acc_cnt, v.len);
    chk("sb_empty", sb_q.size(), 0);
    chk("idle_not_busy", busy, 0);
    if (v.len == 0) begin
      chk("len0_latency", done_cyc - st, 1);
      chk("len0_no_valid", valid_cnt, 0);
    end
    $display("run %s: mode=%0d len=%0d words=%0d nexts=%0d", nm, v.md, v.len, acc_cnt, next_cnt);
    sb_q.delete();
    rand_ready = 1'b0;
    m_ready = 1'b1;
  endtask

  initial begin
    vec_t pr;
    vecs[0] = '{md: 1'b0, len: 10,  rnd: 1'b0, hold: 1'b1, exp_next: 0};
    vecs[1] = '{md: 1'b0, len: 100, rnd: 1'b0, hold: 1'b0, exp_next: 2};
    vecs[2] = '{md: 1'b1, len: 34,  rnd: 1'b0, hold: 1'b0, exp_next: 0};
    vecs[3] = '{md: 1'b1, len: 35,  rnd: 1'b0, hold: 1'b0, exp_next: 1};
    vecs[4] = '{md: 1'b0, len: 0,   rnd: 1'b0, hold: 1'b0, exp_next: 0};
    vecs[5] = '{md: 1'b1, len: 200, rnd: 1'b1, hold: 1'b0, exp_next: 5};
    vecs[6] = '{md: 1'b0, len: 42,  rnd: 1'b0, hold: 1'b0, exp_next: 0};
    vecs[7] = '{md: 1'b0, len: 43,  rnd: 1'b1, hold: 1'b0, exp_next: 1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_core_next", core_next, 0);
    chk("rst_core_addr", core_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // asynchronous reset in the middle of a mode-0 block
    clear_counters();
    m_ready = 1'b1;
    load_expected(1'b0, 100);
    @(posedge clk); #1;
    mode = 1'b0; out_len = 16'd100; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 2000 && acc_cnt < 20; k++) @(posedge clk);
    chk("reach_word20", acc_cnt >= 20, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_data", m_data, 0);
    chk("arst_m_last", m_last, 0);
    chk("arst_core_next", core_next, 0);
    chk("arst_core_addr", core_addr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    $display("run mid_reset: words before reset=%0d", acc_cnt);
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    pr = '{md: 1'b0, len: 50, rnd: 1'b0, hold: 1'b0, exp_next: 1};
    run_vec(pr, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
